// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of
// meas_in over a selectable gate window and exposes the count in parallel and serially.
module ro_freq_meter #(
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_in,
  input  logic [1:0]       gate_sel,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [CNT_W-1:0] result,
  input  logic             rd_shift,
  output logic             sout
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic {IDLE, GATE} state_e;

  state_e           state_q, state_d;
  logic [SS-1:0]    sync_q;
  logic             hist_q;
  logic [13:0]      win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             iovf_q, iovf_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] shf_q, shf_d;
  logic             done_q, done_d;
  logic             rise;
  logic [CNT_W-1:0] cnt_nx;
  logic             iovf_nx;
  logic [13:0]      win_ld;

  assign rise = sync_q[SS-1] & ~hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SS-2:0], meas_in};
      hist_q <= sync_q[SS-1];
    end
  end

  always_comb begin
    win_ld = 14'd255;
    unique case (gate_sel)
      2'd0: win_ld = 14'd255;
      2'd1: win_ld = 14'd1023;
      2'd2: win_ld = 14'd4095;
      2'd3: win_ld = 14'd16383;
    endcase
  end

  // Saturating edge count; an edge at full scale only raises overflow.
  always_comb begin
    cnt_nx  = cnt_q;
    iovf_nx = iovf_q;
    if (rise) begin
      if (&cnt_q) iovf_nx = 1'b1;
      else        cnt_nx  = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    iovf_d  = iovf_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    shf_d   = rd_shift ? {shf_q[CNT_W-2:0], 1'b0} : shf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GATE;
          win_d   = win_ld;
          cnt_d   = '0;
          iovf_d  = 1'b0;
        end
      end
      GATE: begin
        win_d  = win_q - 14'd1;
        cnt_d  = cnt_nx;
        iovf_d = iovf_nx;
        if (win_q == 14'd0) begin
          state_d = IDLE;
          win_d   = '0;
          res_d   = cnt_nx;
          ovf_d   = iovf_nx;
          shf_d   = cnt_nx;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      iovf_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      shf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      iovf_q  <= iovf_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      shf_q   <= shf_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q == GATE);
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign result = res_q;
  assign sout   = shf_q[CNT_W-1];

endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboard bench for ro_freq_meter: expected results queued at start,
// checked by a monitor on every done pulse.
module tb_ro_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_in = 1'b0;
  logic [1:0]  gate_sel = 2'd0;
  logic        start = 1'b0;
  logic        rd_shift = 1'b0;
  logic        busy, done, ovf, sout;
  logic [11:0] result;

  typedef struct {
    int n;
    int cnt;
    int ov;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntot = 0;
  int   bcnt = 0;
  int   mode = 0;
  int   ph = 0;

  ro_freq_meter #(.CNT_W(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .meas_in(meas_in),
    .gate_sel(gate_sel), .start(start), .busy(busy),
    .done(done), .ovf(ovf), .result(result),
    .rd_shift(rd_shift), .sout(sout)
  );

  always #5 clk = ~clk;

  // 0: low, 1: high, 2: clk/2 toggle, 3: clk/4 square
  always @(posedge clk) begin
    #1;
    ph = ph + 1;
    case (mode)
      0: meas_in = 1'b0;
      1: meas_in = 1'b1;
      2: meas_in = ~meas_in;
      default: if (ph % 2 == 0) meas_in = ~meas_in;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) bcnt = 0;
    else begin
      if (busy) bcnt++;
      if (done) begin
        if (q.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_done: result %0d", result);
        end else begin
          e = q.pop_front();
          chk("result", int'(result), e.cnt);
          chk("ovf", int'(ovf), e.ov);
          chk("busy_len", bcnt, e.n);
        end
        bcnt = 0;
      end
    end
  end

  task automatic go(input logic [1:0] sel, input int n,
                    input int c, input int o, input bit push);
    exp_t e;
    @(posedge clk); #1;
    gate_sel = sel;
    start = 1'b1;
    if (push) begin
      e.n = n; e.cnt = c; e.ov = o;
      q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int i;
    i = 0;
    @(negedge clk);
    while (!done && i < lim) begin
      @(negedge clk);
      i++;
    end
    if (!done) begin
      ntot++;
      $display("FAIL wait_done: timeout after %0d cycles, want done", lim);
    end
  endtask

  task automatic set_mode(input int m);
    @(posedge clk); #1;
    mode = m;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    logic [11:0] rv;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_sout", int'(sout), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    set_mode(1);
    go(2'd0, 256, 0, 0, 1'b1);
    wait_done(400);

    set_mode(3);
    go(2'd0, 256, 64, 0, 1'b1);
    wait_done(400);
    @(posedge clk); #1;
    rd_shift = 1'b1;
    rv = 12'h040;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("sout_%0d", k), int'(sout), int'(rv[11-k]));
    end
    @(negedge clk);
    chk("sout_drained", int'(sout), 0);
    @(posedge clk); #1;
    rd_shift = 1'b0;

    go(2'd0, 256, 64, 0, 1'b1);
    repeat (98) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400);
    repeat (20) @(negedge clk);
    chk("no_restart_busy", int'(busy), 0);

    go(2'd1, 1024, 256, 0, 1'b1);
    wait_done(1200);

    go(2'd0, 256, 64, 0, 1'b1);
    q.push_back('{n: 256, cnt: 64, ov: 0});
    #0 start = 1'b1;
    wait_done(400);
    chk("b2b_gap_busy", int'(busy), 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_restart_busy", int'(busy), 1);
    wait_done(400);

    set_mode(2);
    go(2'd3, 16384, 4095, 1, 1'b1);
    rd_shift = 1'b1;
    wait_done(17000);
    chk("reload_wins", int'(sout), 1);
    @(posedge clk); #1 rd_shift = 1'b0;

    set_mode(0);
    go(2'd3, 16384, 0, 0, 1'b1);
    wait_done(17000);

    set_mode(3);
    go(2'd0, 256, 64, 0, 1'b0);
    repeat (48) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_sout", int'(sout), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    go(2'd0, 256, 64, 0, 1'b1);
    wait_done(400);

    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
